control_sequencer: RTL and testbench

Instruction-cycle controller for the 4-bit microcontroller, directly downstream of the 2-bit T-state counter. It consumes the T0–T3 timing value and owns the program counter and instruction register. It fetches one 8-bit instruction per four-clock machine cycle and decodes it into per-T-state datapath strobes. It also resolves jumps and branches and handles halt.

---
 rtl/control_sequencer.sv | 165 ++++++++++++++++
 tb/tb_control_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer
// Instruction-cycle controller for the 4-bit microcontroller. It sits directly
// downstream of the 2-bit T-state counter. It fetches one 8-bit instruction per
// four-clock machine cycle and decodes that instruction into per-T-state
// datapath strobes. It also resolves jumps and branches, and it handles halt.
//
// Build option: define SEQ_CALL_EN to add a 4-bit return register. With it,
// opcode C is CALL and opcode D is RET. Without it, C and D behave as NOP.
//
// Ports
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   t_state     in   [1:0] T-state from the timing counter (0=T0 .. 3=T3)
//   instr_in    in   [7:0] program-memory read data at address pc_out
//   zero_flag   in   ALU zero flag (registered in the datapath)
//   carry_flag  in   ALU carry flag (registered in the datapath)
//   pc_out      out  [3:0] program counter / memory address
//   ir_out      out  [7:0] instruction register {opcode, imm}
//   mem_rd      out  program-memory read strobe (T0 of every RUN cycle)
//   alu_op      out  [2:0] ADD/SUB/AND/OR/XOR/NOT select, from ir_out
//   acc_src     out  0 = ALU result, 1 = imm
//   acc_we      out  accumulator write enable (T2)
//   out_we      out  output-port register write enable (T2)
//   halted      out  high while in HALT
//   state_dbg   out  [1:0] FSM state (0 SYNC, 1 RUN, 2 HALT) for observation

module control_sequencer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] t_state,
  input  logic [7:0] instr_in,
  input  logic       zero_flag,
  input  logic       carry_flag,
  output logic [3:0] pc_out,
  output logic [7:0] ir_out,
  output logic       mem_rd,
  output logic [2:0] alu_op,
  output logic       acc_src,
  output logic       acc_we,
  output logic       out_we,
  output logic       halted,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_OUT = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JC  = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;
`ifdef SEQ_CALL_EN
  localparam logic [3:0] OP_CALL = 4'hC;
  localparam logic [3:0] OP_RET  = 4'hD;
`endif

  state_t     state;
  logic [3:0] opcode;
  logic [3:0] imm;
  logic [3:0] pc_inc;
  logic [3:0] next_pc;
  logic       run;
  logic       is_acc_op;

`ifdef SEQ_CALL_EN
  logic [3:0] ret_q;
`endif

  assign opcode    = ir_out[7:4];
  assign imm       = ir_out[3:0];
  assign pc_inc    = pc_out + 4'd1;   // 4-bit add, so F wraps to 0
  assign run       = (state == ST_RUN);
  assign state_dbg = state;

  // Next PC is derived from ir_out only. The branch flags are consumed
  // at the edge that ends T3, which is the only edge that loads pc_out.
  always_comb begin
    next_pc = pc_inc;
    case (opcode)
      OP_JMP:  next_pc = imm;
      OP_JZ:   next_pc = zero_flag  ? imm : pc_inc;
      OP_JC:   next_pc = carry_flag ? imm : pc_inc;
`ifdef SEQ_CALL_EN
      OP_CALL: next_pc = imm;
      OP_RET:  next_pc = ret_q;
`endif
      default: next_pc = pc_inc;
    endcase
  end

  // The ALU select and the accumulator source are pure decodes of ir_out.
  // They have no dependency on instr_in, so they only change when the IR loads.
  always_comb begin
    alu_op = 3'b000;
    case (opcode)
      OP_ADD:  alu_op = 3'b000;
      OP_SUB:  alu_op = 3'b001;
      OP_AND:  alu_op = 3'b010;
      OP_OR:   alu_op = 3'b011;
      OP_XOR:  alu_op = 3'b100;
      OP_NOT:  alu_op = 3'b101;
      default: alu_op = 3'b000;
    endcase
  end

  assign acc_src   = (opcode == OP_LDI);
  assign is_acc_op = (opcode >= OP_LDI) && (opcode <= OP_NOT);

  // The strobes are active only in RUN. During SYNC and HALT they are all low.
  assign mem_rd = run && (t_state == 2'd0);
  assign acc_we = run && (t_state == 2'd2) && is_acc_op;
  assign out_we = run && (t_state == 2'd2) && (opcode == OP_OUT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_SYNC;
      pc_out <= 4'h0;
      ir_out <= 8'h00;
      halted <= 1'b0;
`ifdef SEQ_CALL_EN
      ret_q  <= 4'h0;
`endif
    end else begin
      case (state)
        // Wait for T3 so that the first RUN cycle is aligned to T0.
        ST_SYNC: begin
          if (t_state == 2'd3) state <= ST_RUN;
        end
        ST_RUN: begin
          if (t_state == 2'd1) ir_out <= instr_in;
          if (t_state == 2'd3) begin
            if (opcode == OP_HLT) begin
              // HALT keeps the HLT address in pc_out.
              state  <= ST_HALT;
              halted <= 1'b1;
            end else begin
              pc_out <= next_pc;
            end
`ifdef SEQ_CALL_EN
            // A nested CALL overwrites the return address.
            if (opcode == OP_CALL) ret_q <= pc_inc;
`endif
          end
        end
        ST_HALT: begin
          // Reset is the only way out of HALT.
          halted <= 1'b1;
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer. The bench owns the T-state counter and a
// 16-word program memory. An instruction-level reference model predicts the
// outputs for every T-state of every machine cycle.
module tb_control_sequencer;

  logic       clk;
  logic       reset_n;
  logic [1:0] t_state;
  logic [7:0] instr_in;
  logic       zero_flag;
  logic       carry_flag;
  logic [3:0] pc_out;
  logic [7:0] ir_out;
  logic       mem_rd;
  logic [2:0] alu_op;
  logic       acc_src;
  logic       acc_we;
  logic       out_we;
  logic       halted;
  logic [1:0] state_dbg;

  logic [7:0] prog [16];
  int         alu_of [16];

  int checks = 0;
  int errors = 0;

  // Reference model state: the current PC, the last fetched instruction,
  // the halt status and the return address.
  logic [3:0] m_pc;
  logic [7:0] m_ir;
  bit         m_halt;
  logic [3:0] m_ret;

  control_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .t_state    (t_state),
    .instr_in   (instr_in),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .pc_out     (pc_out),
    .ir_out     (ir_out),
    .mem_rd     (mem_rd),
    .alu_op     (alu_op),
    .acc_src    (acc_src),
    .acc_we     (acc_we),
    .out_we     (out_we),
    .halted     (halted),
    .state_dbg  (state_dbg)
  );

  assign instr_in = prog[pc_out];

  // Clock and reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_pc"},      pc_out,  8'h0);
    chk({pfx, "_ir"},      ir_out,  8'h00);
    chk({pfx, "_mem_rd"},  mem_rd,  8'h0);
    chk({pfx, "_alu_op"},  alu_op,  8'h0);
    chk({pfx, "_acc_src"}, acc_src, 8'h0);
    chk({pfx, "_acc_we"},  acc_we,  8'h0);
    chk({pfx, "_out_we"},  out_we,  8'h0);
    chk({pfx, "_halted"},  halted,  8'h0);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
  endtask

  // Hold reset across an edge, check the reset values, then release the counter
  // and the block together at T0. Then check the four SYNC cycles.
  task automatic do_reset();
    reset_n    = 1'b0;
    t_state    = 2'd0;
    zero_flag  = 1'b0;
    carry_flag = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("rst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_pc = 4'h0; m_ir = 8'h00; m_halt = 1'b0; m_ret = 4'h0;
    for (int t = 0; t < 4; t++) begin
      t_state = 2'(t);
      @(negedge clk);
      chk("sync_pc",     pc_out, 8'h0);
      chk("sync_mem_rd", mem_rd, 8'h0);
      chk("sync_acc_we", acc_we, 8'h0);
      chk("sync_out_we", out_we, 8'h0);
      chk("sync_halted", halted, 8'h0);
      @(posedge clk); #1;
    end
  endtask

  // Driver and model for one machine cycle (T0..T3).
  // For zf and cf: 0 or 1 forces the flag, 2 randomizes it in every T-state.
  // When stop_at is in 0..3, reset is asserted during that T-state and the
  // outputs are checked at once. In that case the model is not advanced.
  task automatic machine_cycle(input int zf, input int cf, input int stop_at);
    logic [7:0] ins;
    logic [7:0] cur_ir;
    logic [3:0] op;
    logic [3:0] imm;
    logic       z;
    logic       c;
    ins = m_halt ? m_ir : prog[m_pc];
    op  = ins[7:4];
    imm = ins[3:0];
    z = 1'b0; c = 1'b0;
    for (int t = 0; t < 4; t++) begin
      t_state = 2'(t);
      z = (zf == 2) ? 1'($urandom_range(0, 1)) : 1'(zf);
      c = (cf == 2) ? 1'($urandom_range(0, 1)) : 1'(cf);
      zero_flag  = z;
      carry_flag = c;
      if (t == stop_at) begin
        reset_n = 1'b0;
        #2;
        chk_reset_vals("midrst");
        return;
      end
      @(negedge clk);
      cur_ir = (t >= 2) ? ins : m_ir;
      chk("pc",      pc_out,  m_pc);
      chk("mem_rd",  mem_rd,  !m_halt && t == 0);
      chk("ir",      ir_out,  cur_ir);
      chk("alu_op",  alu_op,  8'(alu_of[cur_ir[7:4]]));
      chk("acc_src", acc_src, cur_ir[7:4] == 4'h1);
      chk("acc_we",  acc_we,  !m_halt && t == 2 && op >= 4'h1 && op <= 4'h7);
      chk("out_we",  out_we,  !m_halt && t == 2 && op == 4'h8);
      chk("halted",  halted,  m_halt);
      @(posedge clk); #1;
    end
    // z and c now hold the values that were present at the edge ending T3.
    if (!m_halt) begin
      case (op)
        4'h9: m_pc = imm;
        4'hA: m_pc = z ? imm : 4'((m_pc + 1) % 16);
        4'hB: m_pc = c ? imm : 4'((m_pc + 1) % 16);
`ifdef SEQ_CALL_EN
        4'hC: begin m_ret = 4'((m_pc + 1) % 16); m_pc = imm; end
        4'hD: m_pc = m_ret;
`endif
        4'hF: m_halt = 1'b1;
        default: m_pc = 4'((m_pc + 1) % 16);
      endcase
    end
    m_ir = ins;
  endtask

  // Program 0x15, 0x23, 0x80, then a branch at address 3 to A.
  // A HLT sits at A and at 4. The run halts, and reset is then pulled during T2.
  task automatic run_branch(input logic [7:0] br, input int zf, input int cf);
    clear_prog();
    prog[0] = 8'h15; prog[1] = 8'h23; prog[2] = 8'h80; prog[3] = br;
    prog[4] = 8'hF0; prog[10] = 8'hF0;
    do_reset();
    for (int i = 0; i < 3; i++) machine_cycle(0, 0, 4);
    machine_cycle(zf, cf, 4);
    machine_cycle(0, 0, 4);                       // HLT
    for (int i = 0; i < 3; i++) machine_cycle(2, 2, 4);
    machine_cycle(0, 0, 2);                       // reset during T2 in HALT
  endtask

  initial begin
    alu_of = '{0, 0, 0, 1, 2, 3, 4, 5, 0, 0, 0, 0, 0, 0, 0, 0};
    reset_n = 1'b0; t_state = 2'd0; zero_flag = 1'b0; carry_flag = 1'b0;
    clear_prog();

    // Directed: JZ and JC, with each branch taken and not taken
    run_branch(8'hAA, 1, 0);
    run_branch(8'hAA, 0, 1);
    run_branch(8'hBA, 0, 1);
    run_branch(8'hBA, 1, 0);

    // Directed: a NOP at F wraps the PC to 0
    clear_prog();
    prog[0] = 8'h9F; prog[15] = 8'h00;
    do_reset();
    for (int i = 0; i < 3; i++) machine_cycle(2, 2, 4);

    // Directed: CALL 8 at 2 and RET at 8. The PC runs 2->8->3, or 2->3 without the return register.
    clear_prog();
    prog[0] = 8'h92; prog[2] = 8'hC8; prog[8] = 8'hD0; prog[3] = 8'hF0;
    do_reset();
    for (int i = 0; i < 6; i++) machine_cycle(2, 2, 4);

    // Random programs (no HLT) with random flags, then a reset mid-instruction
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) begin
        prog[i] = 8'($urandom_range(0, 255));
        if (prog[i][7:4] == 4'hF) prog[i][7:4] = 4'hE;
      end
      do_reset();
      for (int i = 0; i < 40; i++) machine_cycle(2, 2, 4);
      machine_cycle(2, 2, int'($urandom_range(0, 3)));
    end

    // Random program that may contain HLT
    for (int i = 0; i < 16; i++) prog[i] = 8'($urandom_range(0, 255));
    do_reset();
    for (int i = 0; i < 40; i++) machine_cycle(2, 2, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
